instr_issuer: RTL

- Instruction sequencer that feeds the accelerator's instruction decoder.
- Reads 64-bit instructions from instruction RAM and presents each one for exactly one cycle, with `instr_enable` high.
- Waits on the completion handshake that the opcode class requires, then moves to the next instruction.
- Sits between the host/control start logic and the decoder. Terminates on the null/halt opcode (8'h82) or when the programmed instruction count is exhausted.

---
 rtl/instr_issuer_pkg.sv | 31 +++
 rtl/instr_issuer_wait_class.sv | 32 +++
 rtl/instr_issuer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/instr_issuer_pkg.sv
// Shared opcode constants, FSM state encoding and helpers for the instruction issuer.
// Also imported by decoder-side checkers through instr_wait_class.
package instr_issuer_pkg;

   localparam logic [7:0] OP_FETCH_A = 8'h01;
   localparam logic [7:0] OP_FETCH_B = 8'h02;
   localparam logic [7:0] OP_FETCH_C = 8'h04;
   localparam logic [7:0] OP_CONV    = 8'h81;
   localparam logic [7:0] OP_KCFG    = 8'h20;
   localparam logic [7:0] OP_REGCFG  = 8'h40;
   localparam logic [7:0] OP_HALT    = 8'h82;
   localparam logic [7:0] OP_HOLD    = 8'h44;

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_READ       = 4'd1,
      S_LOAD       = 4'd2,
      S_ISSUE      = 4'd3,
      S_WAIT_FETCH = 4'd4,
      S_WAIT_CONV  = 4'd5,
      S_HOLD       = 4'd6,
      S_NEXT       = 4'd7,
      S_FINISH     = 4'd8
   } state_e;

   // Completion pulses only count once the current instruction has been issued.
   function automatic logic in_latch_window(input state_e s);
      return !(s inside {S_IDLE, S_READ, S_LOAD});
   endfunction

endpackage

// File: rtl/instr_issuer_wait_class.sv
// Combinational opcode classifier: which completion handshake an opcode waits on.
// Exactly one output is high for any opcode.
module instr_wait_class
   import instr_issuer_pkg::*;
(
   input  logic [7:0] opcode_i,
   output logic       wait_fetch_o,
   output logic       wait_conv_o,
   output logic       hold_o,
   output logic       halt_o,
   output logic       no_wait_o,
   output logic       illegal_o
);

   always_comb begin
      wait_fetch_o = 1'b0;
      wait_conv_o  = 1'b0;
      hold_o       = 1'b0;
      halt_o       = 1'b0;
      no_wait_o    = 1'b0;
      illegal_o    = 1'b0;
      case (opcode_i)
         OP_FETCH_A, OP_FETCH_B, OP_FETCH_C: wait_fetch_o = 1'b1;
         OP_CONV:                            wait_conv_o  = 1'b1;
         OP_KCFG, OP_REGCFG:                 no_wait_o    = 1'b1;
         OP_HOLD:                            hold_o       = 1'b1;
         OP_HALT:                            halt_o       = 1'b1;
         default:                            illegal_o    = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: fetches instructions from RAM, presents each for one cycle
// to the decoder and waits on the completion handshake its opcode class needs.
//
// state      | meaning
// IDLE       | waiting for start
// READ       | imem read strobe at pc
// LOAD       | capture RAM data into instruction
// ISSUE      | instr_enable high, advance pc/count, pick wait by opcode
// WAIT_FETCH | wait for latched fetch_done
// WAIT_CONV  | wait for latched conv_done
// HOLD       | wait for latched resume
// NEXT       | more instructions left -> READ
// FINISH     | done pulse, back to IDLE
module instr_issuer
   import instr_issuer_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int INSTR_WIDTH = 64,
   parameter int CNT_WIDTH   = 11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   input  logic [CNT_WIDTH-1:0]   instr_count,
   output logic                   imem_rd_en,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rd_data,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   instr_enable,
   input  logic                   fetch_done,
   input  logic                   conv_done,
   input  logic                   resume,
   output logic                   busy,
   output logic                   done,
   output logic                   bad_opcode,
   output logic [CNT_WIDTH-1:0]   issued_cnt
);

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [CNT_WIDTH-1:0]   rem_q, rem_d;
   logic [CNT_WIDTH-1:0]   issued_q, issued_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic                   bad_q, bad_d;
   logic                   fetch_lat_q, fetch_lat_d;
   logic                   conv_lat_q, conv_lat_d;
   logic                   resume_lat_q, resume_lat_d;

   logic                   rd_en_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic                   enable_q;
   logic                   busy_q;
   logic                   done_q;

   logic cls_fetch, cls_conv, cls_hold, cls_halt, cls_no_wait, cls_illegal;
   logic last_issue, last_wait, win;

   instr_wait_class u_wait_class (
      .opcode_i     (instr_q[INSTR_WIDTH-1 -: 8]),
      .wait_fetch_o (cls_fetch),
      .wait_conv_o  (cls_conv),
      .hold_o       (cls_hold),
      .halt_o       (cls_halt),
      .no_wait_o    (cls_no_wait),
      .illegal_o    (cls_illegal)
   );

   // In ISSUE the count has not yet been decremented; in the wait states it has.
   assign last_issue = (rem_q == CNT_WIDTH'(1));
   assign last_wait  = (rem_q == '0);
   assign win        = in_latch_window(state_q);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      rem_d        = rem_q;
      issued_d     = issued_q;
      instr_d      = instr_q;
      bad_d        = bad_q;
      fetch_lat_d  = fetch_lat_q;
      conv_lat_d   = conv_lat_q;
      resume_lat_d = resume_lat_q;

      if (state_q == S_ISSUE) begin
         fetch_lat_d  = 1'b0;
         conv_lat_d   = 1'b0;
         resume_lat_d = 1'b0;
      end
      if (win && fetch_done) fetch_lat_d  = 1'b1;
      if (win && conv_done)  conv_lat_d   = 1'b1;
      if (win && resume)     resume_lat_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               pc_d         = base_addr;
               rem_d        = instr_count;
               issued_d     = '0;
               bad_d        = 1'b0;
               fetch_lat_d  = 1'b0;
               conv_lat_d   = 1'b0;
               resume_lat_d = 1'b0;
               state_d      = (instr_count == '0) ? S_FINISH : S_READ;
            end
         end
         S_READ: state_d = S_LOAD;
         S_LOAD: begin
            instr_d = imem_rd_data;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            issued_d = issued_q + CNT_WIDTH'(1);
            pc_d     = pc_q + ADDR_WIDTH'(1);
            rem_d    = rem_q - CNT_WIDTH'(1);
            if (cls_fetch)      state_d = S_WAIT_FETCH;
            else if (cls_conv)  state_d = S_WAIT_CONV;
            else if (cls_hold)  state_d = S_HOLD;
            else if (cls_halt)  state_d = S_FINISH;
            else if (cls_no_wait || cls_illegal) begin
               bad_d   = bad_q | cls_illegal;
               state_d = last_issue ? S_FINISH : S_NEXT;
            end
         end
         S_WAIT_FETCH: if (fetch_lat_q)  state_d = last_wait ? S_FINISH : S_NEXT;
         S_WAIT_CONV:  if (conv_lat_q)   state_d = last_wait ? S_FINISH : S_NEXT;
         S_HOLD:       if (resume_lat_q) state_d = last_wait ? S_FINISH : S_NEXT;
         S_NEXT:       state_d = last_wait ? S_FINISH : S_READ;
         S_FINISH:     state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase

      if (abort && state_q != S_IDLE) state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         rem_q        <= '0;
         issued_q     <= '0;
         instr_q      <= '0;
         bad_q        <= 1'b0;
         fetch_lat_q  <= 1'b0;
         conv_lat_q   <= 1'b0;
         resume_lat_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         rem_q        <= rem_d;
         issued_q     <= issued_d;
         instr_q      <= instr_d;
         bad_q        <= bad_d;
         fetch_lat_q  <= fetch_lat_d;
         conv_lat_q   <= conv_lat_d;
         resume_lat_q <= resume_lat_d;
      end
   end

   // Strobes are decoded from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en_q  <= 1'b0;
         addr_q   <= '0;
         enable_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         rd_en_q  <= (state_d == S_READ);
         if (state_d == S_READ) addr_q <= pc_d;
         enable_q <= (state_d == S_ISSUE);
         busy_q   <= (state_d != S_IDLE);
         done_q   <= (state_d == S_FINISH);
      end
   end

   assign imem_rd_en   = rd_en_q;
   assign imem_addr    = addr_q;
   assign instruction  = instr_q;
   assign instr_enable = enable_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign bad_opcode   = bad_q;
   assign issued_cnt   = issued_q;

endmodule
